// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory arbiter: bus widths, FSM
// states and the requester identifiers used by the round-robin pick.
package mips_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_e;

  typedef enum logic [0:0] {
    CPU  = 1'b0,
    HOST = 1'b1
  } port_id_e;

  // Only whole-word accesses reach memory; the low address bits must be zero.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mips_dmem_arbiter_if.sv
// Load/store request port into the data-memory arbiter; one instance for the
// CPU side and one for the host debug/loader side.
interface mips_dmem_arbiter_if;
  import mips_mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module mips_rr_arb2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,   // bit 0 = CPU, bit 1 = HOST
  input  port_id_e   last,
  output port_id_e   grant
);

  always_comb begin
    grant = CPU;
    if (req[1] && (!req[0] || last == CPU)) begin
      grant = HOST;
    end
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the 256-byte data memory between the CPU load/store port and the
// host port; each access takes IDLE -> ISSUE -> DONE on a 1-cycle-latency RAM.
module mips_dmem_arbiter
  import mips_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  mips_dmem_arbiter_if.slave  cpu,
  mips_dmem_arbiter_if.slave  host,
  output logic                cpu_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e            state_q, state_d;
  port_id_e          last_q, last_d;
  port_id_e          gnt_q, gnt_d;
  port_id_e          arb_gnt;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic              host_err_q, host_err_d;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mis;

  mips_rr_arb2 u_arb (
    .req   ({host.req, cpu.req}),
    .last  (last_q),
    .grant (arb_gnt)
  );

  always_comb begin
    if (arb_gnt == CPU) begin
      sel_we    = cpu.we;
      sel_addr  = cpu.addr;
      sel_wdata = cpu.wdata;
    end else begin
      sel_we    = host.we;
      sel_addr  = host.addr;
      sel_wdata = host.wdata;
    end
    sel_mis = is_misaligned(sel_addr[1:0]);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    host_ack_d  = 1'b0;
    cpu_err_d   = 1'b0;
    host_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu.req || host.req) begin
          // The memory strobe is registered here so it is valid throughout ISSUE.
          gnt_d       = arb_gnt;
          we_d        = sel_we;
          err_d       = sel_mis;
          mem_en_d    = !sel_mis;
          mem_we_d    = sel_we && !sel_mis;
          mem_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = sel_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cpu_ack_d  = (gnt_q == CPU);
        host_ack_d = (gnt_q == HOST);
        cpu_err_d  = (gnt_q == CPU) && err_q;
        host_err_d = (gnt_q == HOST) && err_q;
        state_d    = DONE;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= HOST;
      gnt_q       <= CPU;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      host_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      host_ack_q  <= host_ack_d;
      cpu_err_q   <= cpu_err_d;
      host_err_q  <= host_err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign cpu.ack   = cpu_ack_q;
  assign host.ack  = host_ack_q;
  assign cpu.err   = cpu_err_q;
  assign host.err  = host_err_q;

  // RAM read data arrives in DONE, too late to register, so it is gated through.
  assign cpu.rdata  = (cpu_ack_q && !cpu_err_q && !we_q) ? mem_rdata : '0;
  assign host.rdata = (host_ack_q && !host_err_q && !we_q) ? mem_rdata : '0;

  assign cpu_stall = reset_n && cpu.req && !cpu_ack_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter: a word-addressed RAM model, a
// reference image of memory and per-port scoreboards of expected responses.
module tb_mips_dmem_arbiter;
  import mips_mem_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_dmem_arbiter_if cpu_if ();
  mips_dmem_arbiter_if host_if ();

  logic              cpu_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mips_dmem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (cpu_if),
    .host      (host_if),
    .cpu_stall (cpu_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [DATA_W-1:0] mem_array [64];
  logic [DATA_W-1:0] ref_mem [64];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr[ADDR_W-1:2]] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr[ADDR_W-1:2]];
    end
  end

  exp_t cpu_q[$];
  exp_t host_q[$];
  int   checks = 0;
  int   failures = 0;

  int          cpu_ack_cyc;
  int          host_ack_cyc;
  logic [15:0] en_log;
  logic [15:0] stall_log;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    exp_t e;
    e.err   = (addr[1:0] != 2'b00);
    e.rdata = (e.err || we) ? '0 : ref_mem[addr[ADDR_W-1:2]];
    if (!e.err && we) ref_mem[addr[ADDR_W-1:2]] = wdata;
    return e;
  endfunction

  task automatic start_cpu(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    cpu_q.push_back(predict(we, addr, wdata));
    cpu_if.we    = we;
    cpu_if.addr  = addr;
    cpu_if.wdata = wdata;
    cpu_if.req   = 1'b1;
  endtask

  task automatic start_host(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    host_q.push_back(predict(we, addr, wdata));
    host_if.we    = we;
    host_if.addr  = addr;
    host_if.wdata = wdata;
    host_if.req   = 1'b1;
  endtask

  // Called right after the edge that starts cycle 0; samples each cycle on the
  // falling edge and drops a port's request in the cycle after its ack.
  task automatic run(input int max_cyc);
    logic drop_cpu, drop_host;
    exp_t e;
    cpu_ack_cyc  = -1;
    host_ack_cyc = -1;
    en_log       = '0;
    stall_log    = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      en_log[c]    = mem_en;
      stall_log[c] = cpu_stall;
      drop_cpu     = 1'b0;
      drop_host    = 1'b0;
      if (!cpu_if.ack)  check("cpu_rdata_no_ack", cpu_if.rdata, '0);
      if (!host_if.ack) check("host_rdata_no_ack", host_if.rdata, '0);
      if (cpu_if.ack) begin
        if (cpu_q.size() == 0) begin
          check("cpu_spurious_ack", 32'(cpu_if.ack), 32'd0);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", cpu_if.rdata, e.rdata);
          check("cpu_err", 32'(cpu_if.err), 32'(e.err));
          cpu_ack_cyc = c;
          drop_cpu    = 1'b1;
        end
      end
      if (host_if.ack) begin
        if (host_q.size() == 0) begin
          check("host_spurious_ack", 32'(host_if.ack), 32'd0);
        end else begin
          e = host_q.pop_front();
          check("host_rdata", host_if.rdata, e.rdata);
          check("host_err", 32'(host_if.err), 32'(e.err));
          host_ack_cyc = c;
          drop_host    = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (drop_cpu)  cpu_if.req = 1'b0;
      if (drop_host) host_if.req = 1'b0;
      if (cpu_q.size() == 0 && host_q.size() == 0 && !cpu_if.req && !host_if.req) break;
    end
    if (cpu_q.size() != 0 || host_q.size() != 0) begin
      check("ack_timeout_pending", 32'(cpu_q.size() + host_q.size()), 32'd0);
      cpu_q.delete();
      host_q.delete();
      cpu_if.req  = 1'b0;
      host_if.req = 1'b0;
    end
  endtask

  initial begin
    cpu_if.req = 1'b0;  cpu_if.we = 1'b0;  cpu_if.addr = '0;  cpu_if.wdata = '0;
    host_if.req = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem_array[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i]   = 32'hA500_0000 | 32'(i);
    end
    mem_array[2] = 32'hDEAD_BEEF;
    ref_mem[2]   = 32'hDEAD_BEEF;

    // Reset values, with a CPU request present to show the stall is masked.
    cpu_if.req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_acks", {30'd0, cpu_if.ack, host_if.ack}, 32'd0);
    check("rst_errs", {30'd0, cpu_if.err, host_if.err}, 32'd0);
    check("rst_cpu_rdata", cpu_if.rdata, '0);
    check("rst_host_rdata", host_if.rdata, '0);
    check("rst_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, '0);
    cpu_if.req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // First tie after reset: CPU wins, host follows three cycles later.
    start_cpu(1'b0, 8'h08, '0);
    start_host(1'b0, 8'h10, '0);
    run(12);
    check("tie1_cpu_ack_cycle", 32'(cpu_ack_cyc), 32'd2);
    check("tie1_host_ack_cycle", 32'(host_ack_cyc), 32'd5);

    // Single CPU load from 0x08.
    start_cpu(1'b0, 8'h08, '0);
    run(8);
    check("load_ack_cycle", 32'(cpu_ack_cyc), 32'd2);
    check("load_mem_en_c0", 32'(en_log[0]), 32'd0);
    check("load_mem_en_c1", 32'(en_log[1]), 32'd1);
    check("load_mem_en_c2", 32'(en_log[2]), 32'd0);
    check("load_stall_c0", 32'(stall_log[0]), 32'd1);
    check("load_stall_c1", 32'(stall_log[1]), 32'd1);
    check("load_stall_c2", 32'(stall_log[2]), 32'd0);

    // Host store, then CPU load of the same word.
    start_host(1'b1, 8'h2C, 32'h1234_5678);
    run(8);
    check("hstore_ack_cycle", 32'(host_ack_cyc), 32'd2);
    check("hstore_mem_word", mem_array[11], 32'h1234_5678);
    start_cpu(1'b0, 8'h2C, '0);
    run(8);
    check("cload_ack_cycle", 32'(cpu_ack_cyc), 32'd2);

    // Tie with CPU granted last: host goes first, CPU sees the worst-case stall.
    start_cpu(1'b0, 8'h14, '0);
    start_host(1'b0, 8'h18, '0);
    run(12);
    check("tie2_host_ack_cycle", 32'(host_ack_cyc), 32'd2);
    check("tie2_cpu_ack_cycle", 32'(cpu_ack_cyc), 32'd5);
    check("tie2_stall_c4", 32'(stall_log[4]), 32'd1);
    check("tie2_stall_c5", 32'(stall_log[5]), 32'd0);

    // Misaligned CPU store: error ack, no memory strobe, memory untouched.
    start_cpu(1'b1, 8'h0B, 32'hFFFF_FFFF);
    run(8);
    check("mis_ack_cycle", 32'(cpu_ack_cyc), 32'd2);
    check("mis_mem_en_log", 32'(en_log), 32'd0);
    check("mis_mem_word", mem_array[2], ref_mem[2]);

    // Reset during ISSUE of a host load abandons it without an ack.
    start_host(1'b0, 8'h20, '0);
    host_q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_issue_mem_en", 32'(mem_en), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    host_if.req = 1'b0;
    cpu_if.req  = 1'b1;
    @(negedge clk);
    check("rst_mid_host_ack", 32'(host_if.ack), 32'd0);
    check("rst_mid_mem_en", 32'(mem_en), 32'd0);
    check("rst_mid_host_rdata", host_if.rdata, '0);
    check("rst_mid_cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    cpu_if.req = 1'b0;
    reset_n    = 1'b1;
    @(posedge clk);
    #1;

    // Pointer is back to host after reset, so the CPU wins this tie.
    start_cpu(1'b0, 8'h2C, '0);
    start_host(1'b0, 8'h08, '0);
    run(12);
    check("tie3_cpu_ack_cycle", 32'(cpu_ack_cyc), 32'd2);
    check("tie3_host_ack_cycle", 32'(host_ack_cyc), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
